// File: rtl/sp_render.sv
// sp_render: sprite pixel generator, consumer side of secondary OAM.
//
// Loads the evaluated sprite slots from secondary OAM during the fetch window
// (one slot per PPU cycle starting at LOAD_COL) and, on visible cycles 1..256
// of the next scanline, emits the highest-priority opaque sprite pixel.
//
// Optional feature: define SP_LEFT_CLIP_EN to add show_left_sp, which blanks
// sprite output for pixels 0..7 when low.
//
// Ports:
//   clk, clk_en, rst_n  master clock, PPU clock enable, async active-low reset
//   row, col            current scanline / cycle
//   render_en           sprites enabled on a visible/pre-render line
//   sprite0_in_sec      OAM sprite 0 sits in secondary slot 0 this line
//   show_left_sp        (SP_LEFT_CLIP_EN only) 0 blanks pixels 0..7
//   sec_oam_rd_idx      secondary OAM slot being read
//   sec_oam_rd_data     {active, y_pos[7:0], tile_idx[7:0], attribute[7:0],
//                        x_pos[7:0], bitmap_hi[7:0], bitmap_lo[7:0]}
//   sp_pixel            winning colour index, 0 = transparent
//   sp_palette          winning attribute[1:0]
//   sp_priority         winning attribute[5], 1 = behind background
//   sp_zero             winning opaque pixel came from OAM sprite 0
module sp_render #(
    parameter int         NUM_SLOTS = 8,
    parameter logic [8:0] LOAD_COL  = 9'd321
) (
    input  logic        clk,
    input  logic        clk_en,
    input  logic        rst_n,
    input  logic [8:0]  row,
    input  logic [8:0]  col,
    input  logic        render_en,
    input  logic        sprite0_in_sec,
`ifdef SP_LEFT_CLIP_EN
    input  logic        show_left_sp,
`endif
    output logic [2:0]  sec_oam_rd_idx,
    input  logic [48:0] sec_oam_rd_data,
    output logic [1:0]  sp_pixel,
    output logic [1:0]  sp_palette,
    output logic        sp_priority,
    output logic        sp_zero
);
    localparam int SW = $clog2(NUM_SLOTS);

    logic [7:0]    lo    [NUM_SLOTS];
    logic [7:0]    hi    [NUM_SLOTS];
    logic [7:0]    x_cnt [NUM_SLOTS];
    logic [7:0]    attr  [NUM_SLOTS];
    logic          spr0_valid;
    logic [8:0]    load_off;
    logic          in_load;
    logic          in_render;
    logic          clip;
    logic          win_found;
    logic [SW-1:0] win;
    logic [7:0]    ld_lo;
    logic [7:0]    ld_hi;
    logic          unused_ok;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    // Modular offset: values 0..NUM_SLOTS-1 mark the load window.
    assign load_off       = col - LOAD_COL;
    assign sec_oam_rd_idx = load_off[2:0];
    assign in_load        = load_off < 9'(NUM_SLOTS);
    assign in_render      = render_en && col >= 9'd1 && col <= 9'd256;

`ifdef SP_LEFT_CLIP_EN
    assign clip = !show_left_sp && col <= 9'd8;
`else
    assign clip = 1'b0;
`endif

    // Inactive slots load as transparent; attribute[6] mirrors the bitmap.
    assign ld_lo = !sec_oam_rd_data[48] ? 8'h00 :
                   sec_oam_rd_data[30] ? rev8(sec_oam_rd_data[7:0]) : sec_oam_rd_data[7:0];
    assign ld_hi = !sec_oam_rd_data[48] ? 8'h00 :
                   sec_oam_rd_data[30] ? rev8(sec_oam_rd_data[15:8]) : sec_oam_rd_data[15:8];

    assign unused_ok = ^{row, sec_oam_rd_data[47:32]};

    // Descending scan so the lowest-index opaque slot is the last to overwrite.
    always_comb begin
        win_found = 1'b0;
        win       = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (x_cnt[i] == 8'd0 && (hi[i][7] || lo[i][7])) begin
                win_found = 1'b1;
                win       = SW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                lo[i]    <= '0;
                hi[i]    <= '0;
                x_cnt[i] <= '0;
                attr[i]  <= '0;
            end
            spr0_valid  <= 1'b0;
            sp_pixel    <= '0;
            sp_palette  <= '0;
            sp_priority <= 1'b0;
            sp_zero     <= 1'b0;
        end else if (clk_en) begin
            sp_pixel    <= '0;
            sp_palette  <= '0;
            sp_priority <= 1'b0;
            sp_zero     <= 1'b0;
            if (in_load) begin
                lo[load_off[SW-1:0]]    <= ld_lo;
                hi[load_off[SW-1:0]]    <= ld_hi;
                x_cnt[load_off[SW-1:0]] <= sec_oam_rd_data[23:16];
                attr[load_off[SW-1:0]]  <= sec_oam_rd_data[31:24];
                if (load_off == 9'd0) spr0_valid <= sprite0_in_sec;
            end
            if (in_render) begin
                if (win_found && !clip) begin
                    sp_pixel    <= {hi[win][7], lo[win][7]};
                    sp_palette  <= attr[win][1:0];
                    sp_priority <= attr[win][5];
                    sp_zero     <= (win == '0) && spr0_valid;
                end
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (x_cnt[i] != 8'd0) begin
                        x_cnt[i] <= x_cnt[i] - 8'd1;
                    end else begin
                        lo[i] <= {lo[i][6:0], 1'b0};
                        hi[i] <= {hi[i][6:0], 1'b0};
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_sp_render.sv
// tb_sp_render: table-driven bench for sp_render.
module tb_sp_render;
    typedef struct {
        logic [7:0][48:0] slots;
        logic             s0;
        logic             ren;
        int               f0;
        int               l0;
        logic [5:0]       v0;
        int               f1;
        int               l1;
        logic [5:0]       v1;
    } scen_t;

    logic             clk = 1'b0;
    logic             clk_en = 1'b0;
    logic             rst_n = 1'b0;
    logic             render_en = 1'b0;
    logic             sprite0_in_sec = 1'b0;
    logic [8:0]       row = 9'd0;
    logic [8:0]       col = 9'd0;
    logic [2:0]       sec_oam_rd_idx;
    logic [48:0]      sec_oam_rd_data;
    logic [7:0][48:0] sec = '0;
    logic [1:0]       sp_pixel;
    logic [1:0]       sp_palette;
    logic             sp_priority;
    logic             sp_zero;
`ifdef SP_LEFT_CLIP_EN
    logic             show_left_sp = 1'b1;
`endif
    int               checks = 0;
    int               errors = 0;
    scen_t            t [7];
    scen_t            zs;
    scen_t            rs;

    always #5 clk = ~clk;

    assign sec_oam_rd_data = sec[sec_oam_rd_idx];

    sp_render dut (
        .clk            (clk),
        .clk_en         (clk_en),
        .rst_n          (rst_n),
        .row            (row),
        .col            (col),
        .render_en      (render_en),
        .sprite0_in_sec (sprite0_in_sec),
`ifdef SP_LEFT_CLIP_EN
        .show_left_sp   (show_left_sp),
`endif
        .sec_oam_rd_idx (sec_oam_rd_idx),
        .sec_oam_rd_data(sec_oam_rd_data),
        .sp_pixel       (sp_pixel),
        .sp_palette     (sp_palette),
        .sp_priority    (sp_priority),
        .sp_zero        (sp_zero)
    );

    function automatic logic [48:0] mk(input logic a, input logic [7:0] at, x, h, l);
        return {a, 16'h0000, at, x, h, l};
    endfunction

    function automatic scen_t mks(input logic s0, ren, input int f0, l0, input logic [5:0] v0,
                                  input int f1, l1, input logic [5:0] v1);
        scen_t s;
        s.slots = '0;
        s.s0 = s0;
        s.ren = ren;
        s.f0 = f0;
        s.l0 = l0;
        s.v0 = v0;
        s.f1 = f1;
        s.l1 = l1;
        s.v1 = v1;
        return s;
    endfunction

    // Expected {pixel, palette, priority, zero} after the edge presenting col c.
    function automatic logic [5:0] expv(input scen_t s, input int c);
        if (!s.ren) return 6'd0;
        if (c >= s.f0 && c <= s.l0) return s.v0;
        if (c >= s.f1 && c <= s.l1) return s.v1;
        return 6'd0;
    endfunction

    task automatic check(input string nm, input int c, input logic [5:0] got, input logic [5:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s col=%0d got=%b want=%b", nm, c, got, want);
        end
    endtask

    // One PPU cycle: a single clk_en edge followed by three gated edges.
    task automatic tick(input int c);
        col = 9'(c);
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        clk_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic load(input scen_t s, input string nm);
        sec = s.slots;
        sprite0_in_sec = s.s0;
        render_en = s.ren;
        for (int c = 321; c <= 340; c++) begin
            tick(c);
            if (c <= 328) check({nm, "_idx"}, c, {3'b000, sec_oam_rd_idx}, 6'(c - 321));
            check({nm, "_ld"}, c, {sp_pixel, sp_palette, sp_priority, sp_zero}, 6'd0);
        end
    endtask

    task automatic render(input scen_t s, input int a, input int b, input string nm);
        for (int c = a; c <= b; c++) begin
            tick(c);
            check(nm, c, {sp_pixel, sp_palette, sp_priority, sp_zero}, expv(s, c));
        end
    endtask

    initial begin
        t[0] = mks(1'b1, 1'b1, 11, 11, 6'b01_11_0_1, -1, -2, 6'd0);
        t[0].slots[0] = mk(1'b1, 8'h03, 8'd10, 8'h00, 8'h80);
        t[1] = mks(1'b1, 1'b1, 1, 8, 6'b11_00_1_0, -1, -2, 6'd0);
        t[1].slots[2] = mk(1'b1, 8'h20, 8'd0, 8'hFF, 8'hFF);
        t[1].slots[5] = mk(1'b1, 8'h01, 8'd0, 8'hFF, 8'hFF);
        t[2] = mks(1'b0, 1'b1, 101, 101, 6'b01_00_0_0, 102, 102, 6'b10_00_0_0);
        t[2].slots[3] = mk(1'b1, 8'h40, 8'd100, 8'h02, 8'h01);
        t[3] = mks(1'b0, 1'b1, 253, 256, 6'b01_00_0_0, -1, -2, 6'd0);
        t[3].slots[7] = mk(1'b1, 8'h00, 8'd252, 8'h00, 8'hFF);
        t[4] = mks(1'b1, 1'b1, 21, 22, 6'b10_10_1_0, -1, -2, 6'd0);
        t[4].slots[0] = mk(1'b0, 8'h03, 8'd0, 8'hFF, 8'hFF);
        t[4].slots[1] = mk(1'b1, 8'h22, 8'd20, 8'hC0, 8'h00);
        t[5] = mks(1'b1, 1'b1, 1, 4, 6'b10_00_0_0, 5, 12, 6'b01_01_0_1);
        t[5].slots[0] = mk(1'b1, 8'h01, 8'd4, 8'h00, 8'hFF);
        t[5].slots[1] = mk(1'b1, 8'h00, 8'd0, 8'hFF, 8'h00);
        t[6] = t[0];
        t[6].ren = 1'b0;
        zs = mks(1'b0, 1'b1, -1, -2, 6'd0, -1, -2, 6'd0);
        rs = mks(1'b1, 1'b1, 149, 149, 6'b01_11_0_1, -1, -2, 6'd0);
        rs.slots[0] = mk(1'b1, 8'h03, 8'd148, 8'h00, 8'hFF);

        repeat (3) @(posedge clk);
        #1;
        check("reset", 0, {sp_pixel, sp_palette, sp_priority, sp_zero}, 6'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            load(t[i], $sformatf("s%0d", i));
            render(t[i], 0, 320, $sformatf("s%0d", i));
        end

        load(rs, "rst");
        render(rs, 0, 149, "rst");
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", 149, {sp_pixel, sp_palette, sp_priority, sp_zero}, 6'd0);
        render(zs, 150, 151, "rst_hold");
        rst_n = 1'b1;
        render(zs, 152, 320, "rst_after");
        load(t[0], "post_rst");
        render(t[0], 0, 320, "post_rst");

`ifdef SP_LEFT_CLIP_EN
        begin
            scen_t cs;
            cs = mks(1'b0, 1'b1, 9, 12, 6'b01_00_0_0, -1, -2, 6'd0);
            cs.slots[0] = mk(1'b1, 8'h00, 8'd4, 8'h00, 8'hFF);
            show_left_sp = 1'b0;
            load(cs, "clip");
            render(cs, 0, 320, "clip");
            show_left_sp = 1'b1;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
